// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, widths and bit-period helper
package uart_pkg;
  localparam int BAUD_CNT_WIDTH = 15;
  localparam int UART_D_WIDTH = 8;
  localparam int PACKET_BITS = UART_D_WIDTH + 3;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP1, STOP2} rx_state_e;
  function automatic int calc_baud_max(input int clk_freq, input int baud_rate, input int ovr);
    return ((ovr != 0) ? ovr : clk_freq / baud_rate) - 1;
  endfunction
endpackage

// File: rtl/uart_rx_wfifo_if.sv
// uart_rx_wfifo_if: write port from the UART receiver into the SDRAM wFIFO
interface uart_rx_wfifo_if #(parameter int D_WIDTH = 8);
  logic               wfifo_full;
  logic               wfifo_wr_en;
  logic [D_WIDTH-1:0] wfifo_wr_data;
  modport master (input wfifo_full, output wfifo_wr_en, output wfifo_wr_data);
  modport slave  (output wfifo_full, input wfifo_wr_en, input wfifo_wr_data);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop rx synchronizer with history flop for falling-edge detect
module uart_rx_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic rx,
  output logic level,
  output logic fall
);
  logic s1_q, s2_q, s3_q;
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= rx;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end
  assign level = s2_q;
  assign fall  = s3_q & ~s2_q;
endmodule

// File: rtl/uart_rx_wfifo.sv
// uart_rx_wfifo: 8N2 UART receiver committing good bytes to the wFIFO with error pulses
module uart_rx_wfifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD_RATE    = 9600,
  parameter int D_WIDTH      = 8,
  parameter int BAUD_CNT_OVR = 0
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   rx,
  uart_rx_wfifo_if.master        wfifo,
  output logic                   frame_err,
  output logic                   overrun_err,
  output logic                   rx_busy
);
  localparam logic [BAUD_CNT_WIDTH-1:0] BAUD_MAX = BAUD_CNT_WIDTH'(calc_baud_max(CLK_FREQ, BAUD_RATE, BAUD_CNT_OVR));
  localparam logic [BAUD_CNT_WIDTH-1:0] BAUD_MID = BAUD_MAX >> 1;
  localparam int BC_W = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(D_WIDTH - 1);

  rx_state_e                 state_q, state_d;
  logic [BAUD_CNT_WIDTH-1:0] baud_cnt_q, baud_cnt_d;
  logic [BC_W-1:0]           bit_cnt_q, bit_cnt_d;
  logic [D_WIDTH-1:0]        shift_q, shift_d, data_q, data_d;
  logic                      stop_bad_q, stop_bad_d, good_q, good_d, commit_q, commit_d;
  logic                      level, fall, at_max, commit_ok;

  uart_rx_sync u_sync (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .rx       (rx),
    .level    (level),
    .fall     (fall)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      stop_bad_q <= 1'b0;
      good_q     <= 1'b0;
      commit_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      stop_bad_q <= stop_bad_d;
      good_q     <= good_d;
      commit_q   <= commit_d;
    end
  end

  assign at_max = baud_cnt_q == BAUD_MAX;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    stop_bad_d = stop_bad_q;
    good_d     = good_q;
    commit_d   = 1'b0;
    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        state_d    = fall ? START : IDLE;
      end
      START: if (baud_cnt_q == BAUD_MID) begin
        baud_cnt_d = '0;
        state_d    = level ? IDLE : DATA;
      end
      DATA: if (at_max) begin
        baud_cnt_d = '0;
        shift_d    = {level, shift_q[D_WIDTH-1:1]};
        bit_cnt_d  = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
        state_d    = (bit_cnt_q == BIT_LAST) ? STOP1 : DATA;
      end
      STOP1: if (at_max) begin
        baud_cnt_d = '0;
        stop_bad_d = ~level;
        state_d    = STOP2;
      end
      STOP2: if (at_max) begin
        baud_cnt_d = '0;
        good_d     = ~stop_bad_q & level;
        commit_d   = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // commit happens the cycle after the STOP2 sample; wfifo_full is only looked at here
  assign commit_ok           = commit_q & good_q & ~wfifo.wfifo_full;
  assign data_d              = commit_ok ? shift_q : data_q;
  assign wfifo.wfifo_wr_en   = commit_ok;
  assign wfifo.wfifo_wr_data = data_d;
  assign frame_err           = commit_q & ~good_q;
  assign overrun_err         = commit_q & good_q & wfifo.wfifo_full;
  assign rx_busy             = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_wfifo.sv
// tb_uart_rx_wfifo: directed self-checking bench for uart_rx_wfifo with a 10-clock bit period
module tb_uart_rx_wfifo;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic rx = 1'b1;
  logic frame_err, overrun_err, rx_busy;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int excl = 0;
  logic [7:0] wq[$];
  int tq[$];

  uart_rx_wfifo_if #(.D_WIDTH(8)) wf ();

  uart_rx_wfifo #(
    .CLK_FREQ(100_000_000), .BAUD_RATE(9600), .D_WIDTH(8), .BAUD_CNT_OVR(10)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .rx         (rx),
    .wfifo      (wf.master),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .rx_busy    (rx_busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    cyc++;
    if (wf.wfifo_wr_en === 1'b1) begin
      wq.push_back(wf.wfifo_wr_data);
      tq.push_back(cyc);
    end
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun_err === 1'b1) ov_cnt++;
    if (int'(wf.wfifo_wr_en === 1'b1) + int'(frame_err === 1'b1) + int'(overrun_err === 1'b1) > 1) excl++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop1, input logic stop2);
    rx = 1'b0;
    tick(10);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(10);
    end
    rx = stop1;
    tick(10);
    rx = stop2;
    tick(10);
    rx = 1'b1;
  endtask

  function automatic logic [7:0] qd(input int i);
    return (wq.size() > i) ? wq[i] : 8'hxx;
  endfunction

  function automatic int qt(input int i);
    return (tq.size() > i) ? tq[i] : -1000;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr_en"}, {31'd0, wf.wfifo_wr_en}, 32'd0);
    check({tag, "_wr_data"}, {24'd0, wf.wfifo_wr_data}, 32'd0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_overrun_err"}, {31'd0, overrun_err}, 32'd0);
    check({tag, "_rx_busy"}, {31'd0, rx_busy}, 32'd0);
  endtask

  initial begin
    wf.wfifo_full = 1'b0;
    tick(3);
    check_idle_outputs("reset");
    sys_rst_n = 1'b1;
    tick(3);

    send_frame(8'hA5, 1'b1, 1'b1);
    tick(2);
    check("a5_count", wq.size(), 32'd1);
    check("a5_data", {24'd0, qd(0)}, 32'hA5);
    check("a5_fe", fe_cnt, 32'd0);
    check("a5_ov", ov_cnt, 32'd0);
    check("a5_busy", {31'd0, rx_busy}, 32'd0);
    check("a5_hold", {24'd0, wf.wfifo_wr_data}, 32'hA5);

    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(12);
    check("glitch_count", wq.size(), 32'd1);
    check("glitch_fe", fe_cnt, 32'd0);
    check("glitch_ov", ov_cnt, 32'd0);
    check("glitch_busy", {31'd0, rx_busy}, 32'd0);

    send_frame(8'h3C, 1'b0, 1'b1);
    tick(2);
    check("ferr_fe", fe_cnt, 32'd1);
    check("ferr_count", wq.size(), 32'd1);
    check("ferr_hold", {24'd0, wf.wfifo_wr_data}, 32'hA5);

    wf.wfifo_full = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b1);
    tick(2);
    wf.wfifo_full = 1'b0;
    check("ovr_ov", ov_cnt, 32'd1);
    check("ovr_count", wq.size(), 32'd1);
    check("ovr_fe", fe_cnt, 32'd1);
    send_frame(8'h77, 1'b1, 1'b1);
    tick(2);
    check("x77_count", wq.size(), 32'd2);
    check("x77_data", {24'd0, qd(1)}, 32'h77);

    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h81, 1'b1, 1'b1);
    tick(2);
    check("b2b_count", wq.size(), 32'd5);
    check("b2b_d0", {24'd0, qd(2)}, 32'h00);
    check("b2b_d1", {24'd0, qd(3)}, 32'hFF);
    check("b2b_d2", {24'd0, qd(4)}, 32'h81);
    check("b2b_gap1", qt(3) - qt(2), 32'd110);
    check("b2b_gap2", qt(4) - qt(3), 32'd110);
    check("b2b_fe", fe_cnt, 32'd1);

    rx = 1'b0;
    tick(10);
    rx = 1'b1;
    tick(10);
    rx = 1'b0;
    tick(30);
    tick(5);
    sys_rst_n = 1'b0;
    rx = 1'b1;
    tick(3);
    check_idle_outputs("midrst");
    sys_rst_n = 1'b1;
    tick(5);
    send_frame(8'h81, 1'b1, 1'b1);
    tick(2);
    check("rst_count", wq.size(), 32'd6);
    check("rst_data", {24'd0, qd(5)}, 32'h81);
    check("rst_hold", {24'd0, wf.wfifo_wr_data}, 32'h81);
    check("rst_fe", fe_cnt, 32'd1);
    check("rst_ov", ov_cnt, 32'd1);
    check("excl", excl, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
